// File: rtl/regfile_32x64.sv
// 32x64 integer register file: two combinational read ports, one write port fed by a one-hot decoder.
// Write 1 cycle, read 0 cycles; no backpressure. REGFILE_BYPASS_EN enables same-cycle write-through.
module decoder5_32 (
  input  logic [4:0]  in,
  input  logic        RegWrite,
  output logic [31:0] out
);
  always_comb begin
    out     = '0;
    out[in] = RegWrite;
  end
endmodule

module regfile_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [31:0]           dec_en;
  logic [31:0]           wr_en;
  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] regs_d [32];

  decoder5_32 u_dec (
    .in       (WriteRegister),
    .RegWrite (RegWrite),
    .out      (dec_en)
  );

  // XZR never holds state, so its enable is masked off at the source.
  always_comb begin
    wr_en           = dec_en;
    wr_en[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en[i]) regs_d[i] = WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    ReadData1 = (ReadRegister1 == ZERO_IDX) ? '0 : regs_q[ReadRegister1];
    ReadData2 = (ReadRegister2 == ZERO_IDX) ? '0 : regs_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding ignores reset so the WB value is seen by ID in the same cycle.
    if (RegWrite && (WriteRegister != ZERO_IDX)) begin
      if (WriteRegister == ReadRegister1) ReadData1 = WriteData;
      if (WriteRegister == ReadRegister2) ReadData2 = WriteData;
    end
`else
`endif
  end
endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64; expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_32x64;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int errors = 0;
  int checks = 0;

  regfile_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fill_val(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    logic [63:0] exp1;
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check($sformatf("reset_sweep_p1[%0d]", i), ReadData1, 64'h0);
      check($sformatf("reset_sweep_p2[%0d]", 31 - i), ReadData2, 64'h0);
    end

    for (int i = 0; i < 31; i++) begin
      RegWrite      = 1'b1;
      WriteRegister = 5'(i);
      WriteData     = fill_val(i);
      tick();
    end

    // Write to XZR: no bypass in the write cycle, no state afterwards.
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    #1;
    check("xzr_write_cycle_p1", ReadData1, 64'h0);
    check("xzr_write_cycle_p2", ReadData2, 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("xzr_after_p1", ReadData1, 64'h0);
    check("xzr_after_p2", ReadData2, 64'h0);

    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(30 - i);
      #1;
      check($sformatf("fill_p1[%0d]", i), ReadData1, fill_val(i));
      check($sformatf("fill_p2[%0d]", 30 - i), ReadData2, fill_val(30 - i));
    end

    RegWrite      = 1'b0;
    WriteRegister = 5'd5;
    WriteData     = 64'hDEAD_BEEF_DEAD_BEEF;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    #1;
    check("gate_same_cycle_p2", ReadData2, fill_val(5));
    for (int c = 0; c < 10; c++) tick();
    check("gate_reg5_p1", ReadData1, fill_val(5));
    check("gate_reg5_p2", ReadData2, fill_val(5));

    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'h1;
    tick();
    WriteData     = 64'h2;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd6;
    #1;
    check("hazard_same_cycle", ReadData1, BYPASS ? 64'h2 : 64'h1);
    check("hazard_other_port", ReadData2, fill_val(6));
    tick();
    RegWrite = 1'b0;
    #1;
    check("hazard_next_cycle", ReadData1, 64'h2);

    RegWrite      = 1'b1;
    WriteRegister = 5'd12;
    WriteData     = 64'hCAFE;
    tick();
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd12;
    ReadRegister2 = 5'd12;
    #1;
    check("dual_same_p1", ReadData1, 64'hCAFE);
    check("dual_same_p2", ReadData2, 64'hCAFE);

    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h1234;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd12;
    #1;
    exp1 = BYPASS ? 64'h1234 : fill_val(3);
    check("reset_cycle_reg3", ReadData1, exp1);
    check("reset_cycle_reg12", ReadData2, 64'hCAFE);
    tick();
    reset    = 1'b0;
    RegWrite = 1'b0;
    #1;
    check("collision_reg3", ReadData1, 64'h0);
    check("collision_reg12", ReadData2, 64'h0);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check($sformatf("post_reset_p1[%0d]", i), ReadData1, 64'h0);
      check($sformatf("post_reset_p2[%0d]", 31 - i), ReadData2, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
